mcpu_sysbus: RTL

Parametrised system-bus controller between mcpu_core's memory interface (reg_addr, dram_re, dram_we, data) and the memories and I/O. It replaces fixed wiring with an address decoder covering DRAM, CPU-writable VRAM and memory-mapped I/O. CPU VRAM writes are posted through a FIFO that drains only in GPU-granted slots. It adds vsync-derived frame counting, a sticky vblank flag and a latched keyboard register.

---
 rtl/mcpu_sysbus.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mcpu_sysbus.sv
// mcpu_sysbus: system-bus controller for mcpu_core.
// Decodes the core's address into DRAM, write-only VRAM and memory-mapped I/O.
// CPU VRAM writes are posted through a small FIFO that drains in GPU-granted
// slots. The block also keeps a vsync frame counter, a sticky vblank flag and
// a latched keyboard register.
module mcpu_sysbus #(
  parameter int DATA_WIDTH = 16,
  parameter int DRAM_AW    = 14,
  parameter int VRAM_AW    = 13,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] VRAM_BASE = DATA_WIDTH'(16'h8000),
  parameter logic [DATA_WIDTH-1:0] IO_BASE   = DATA_WIDTH'(16'hC000)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_re,
  input  logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_stall,
  output logic [DRAM_AW-1:0]    dram_addr,
  output logic [DATA_WIDTH-1:0] dram_wdata,
  output logic                  dram_re,
  output logic                  dram_we,
  input  logic [DATA_WIDTH-1:0] dram_rdata,
  input  logic                  vram_grant,
  output logic [VRAM_AW-1:0]    vram_addr,
  output logic [7:0]            vram_wdata,
  output logic                  vram_we,
  input  logic                  vsync,
  input  logic [7:0]            hpaddle,
  input  logic [7:0]            vpaddle,
  input  logic [7:0]            keycode
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [3:0] IO_STATUS = 4'd0;
  localparam logic [3:0] IO_FRAME  = 4'd1;
  localparam logic [3:0] IO_PADDLE = 4'd2;
  localparam logic [3:0] IO_KEY    = 4'd3;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_DRAM = 2'd1,
    RD_IO   = 2'd2
  } rd_sel_e;

  // Address decode results
  logic               sel_dram;
  logic               sel_vram;
  logic               sel_io;
  logic [VRAM_AW-1:0] vram_off;
  logic [3:0]         io_off;

  // FIFO control
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_push;
  logic               fifo_pop;
  logic [PTR_W-1:0]   wr_idx;
  logic [PTR_W-1:0]   rd_idx;

  // I/O access helpers
  logic                  io_wr;
  logic                  key_rd;
  logic                  vsync_edge;
  logic [DATA_WIDTH-1:0] io_rdata;

  // State registers and their next values
  logic [VRAM_AW-1:0]    fifo_addr_q [FIFO_DEPTH];
  logic [VRAM_AW-1:0]    fifo_addr_d [FIFO_DEPTH];
  logic [7:0]            fifo_data_q [FIFO_DEPTH];
  logic [7:0]            fifo_data_d [FIFO_DEPTH];
  logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
  rd_sel_e               rd_sel_q, rd_sel_d;
  logic [DATA_WIDTH-1:0] io_rd_q, io_rd_d;
  logic [DATA_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                  vblank_q, vblank_d;
  logic                  key_valid_q, key_valid_d;
  logic [7:0]            key_q, key_d;
  logic                  vsync_d_q, vsync_d_d;
  logic                  vram_we_q, vram_we_d;
  logic [VRAM_AW-1:0]    vram_addr_q, vram_addr_d;
  logic [7:0]            vram_wdata_q, vram_wdata_d;

  // Unsigned address decode; only low bits of the VRAM offset are kept
  always_comb begin
    sel_dram = 1'b0;
    sel_vram = 1'b0;
    sel_io   = 1'b0;
    if (bus_addr >= IO_BASE) begin
      sel_io = 1'b1;
    end else if (bus_addr >= VRAM_BASE) begin
      sel_vram = 1'b1;
    end else begin
      sel_dram = 1'b1;
    end
    vram_off = bus_addr[VRAM_AW-1:0] - VRAM_BASE[VRAM_AW-1:0];
    io_off   = bus_addr[3:0];
  end

  // DRAM strobes pass straight through when the access decodes to DRAM
  always_comb begin
    if (!reset && sel_dram) begin
      dram_re    = bus_re;
      dram_we    = bus_we;
      dram_addr  = bus_addr[DRAM_AW-1:0];
      dram_wdata = bus_wdata;
    end else begin
      dram_re    = 1'b0;
      dram_we    = 1'b0;
      dram_addr  = {DRAM_AW{1'b0}};
      dram_wdata = {DATA_WIDTH{1'b0}};
    end
  end

  // FIFO occupancy, push/pop decisions and the stall back to the core
  always_comb begin
    fifo_count = wr_ptr_q - rd_ptr_q;
    fifo_empty = (fifo_count == {CNT_W{1'b0}});
    fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    wr_idx     = wr_ptr_q[PTR_W-1:0];
    rd_idx     = rd_ptr_q[PTR_W-1:0];
    fifo_push  = bus_we & sel_vram & ~fifo_full;
    fifo_pop   = vram_grant & ~fifo_empty;
    bus_stall  = ~reset & bus_we & sel_vram & fifo_full;
  end

  // I/O register read value, taken from state before this cycle's updates
  always_comb begin
    io_rdata = {DATA_WIDTH{1'b0}};
    case (io_off)
      IO_STATUS: begin
        io_rdata[0] = fifo_empty;
        io_rdata[1] = fifo_full;
        io_rdata[2] = vblank_q;
      end
      IO_FRAME:  io_rdata = frame_cnt_q;
      IO_PADDLE: io_rdata[15:0] = {vpaddle, hpaddle};
      IO_KEY: begin
        io_rdata[DATA_WIDTH-1] = key_valid_q;
        io_rdata[7:0]          = key_q;
      end
      default:   io_rdata = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Next-state logic for FIFO, read select, counters, flags and VRAM port
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (fifo_push) begin
      fifo_addr_d[wr_idx] = vram_off;
      fifo_data_d[wr_idx] = bus_wdata[7:0];
      wr_ptr_d            = wr_ptr_q + CNT_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (fifo_pop) begin
      rd_ptr_d     = rd_ptr_q + CNT_W'(1);
      vram_we_d    = 1'b1;
      vram_addr_d  = fifo_addr_q[rd_idx];
      vram_wdata_d = fifo_data_q[rd_idx];
    end else begin
      vram_we_d    = 1'b0;
      vram_addr_d  = vram_addr_q;
      vram_wdata_d = vram_wdata_q;
    end

    rd_sel_d = RD_NONE;
    io_rd_d  = {DATA_WIDTH{1'b0}};
    if (bus_re && sel_dram) begin
      rd_sel_d = RD_DRAM;
    end else if (bus_re && sel_io) begin
      rd_sel_d = RD_IO;
      io_rd_d  = io_rdata;
    end else begin
      rd_sel_d = RD_NONE;
    end

    io_wr      = bus_we & sel_io;
    key_rd     = bus_re & sel_io & (io_off == IO_KEY);
    vsync_edge = vsync & ~vsync_d_q;
    vsync_d_d  = vsync;

    // A FRAME write takes priority over a coincident vsync edge
    if (io_wr && io_off == IO_FRAME) begin
      frame_cnt_d = bus_wdata;
    end else if (vsync_edge) begin
      frame_cnt_d = frame_cnt_q + DATA_WIDTH'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    // Setting vblank beats a same-cycle clear
    if (vsync_edge) begin
      vblank_d = 1'b1;
    end else if (io_wr && io_off == IO_STATUS && bus_wdata[2]) begin
      vblank_d = 1'b0;
    end else begin
      vblank_d = vblank_q;
    end

    // A KEY read empties the latch and beats a same-cycle capture
    if (key_rd) begin
      key_valid_d = 1'b0;
      key_d       = 8'h00;
    end else if (keycode != 8'h00 && !key_valid_q) begin
      key_valid_d = 1'b1;
      key_d       = keycode;
    end else begin
      key_valid_d = key_valid_q;
      key_d       = key_q;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= {CNT_W{1'b0}};
      rd_ptr_q     <= {CNT_W{1'b0}};
      rd_sel_q     <= RD_NONE;
      io_rd_q      <= {DATA_WIDTH{1'b0}};
      frame_cnt_q  <= {DATA_WIDTH{1'b0}};
      vblank_q     <= 1'b0;
      key_valid_q  <= 1'b0;
      key_q        <= 8'h00;
      vsync_d_q    <= 1'b0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= {VRAM_AW{1'b0}};
      vram_wdata_q <= 8'h00;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_sel_q     <= rd_sel_d;
      io_rd_q      <= io_rd_d;
      frame_cnt_q  <= frame_cnt_d;
      vblank_q     <= vblank_d;
      key_valid_q  <= key_valid_d;
      key_q        <= key_d;
      vsync_d_q    <= vsync_d_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
    end
  end

  // Read data mux: DRAM data arrives the cycle after the strobe
  always_comb begin
    case (rd_sel_q)
      RD_DRAM: bus_rdata = dram_rdata;
      RD_IO:   bus_rdata = io_rd_q;
      default: bus_rdata = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign vram_we    = vram_we_q;
  assign vram_addr  = vram_addr_q;
  assign vram_wdata = vram_wdata_q;

endmodule
